// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
//   Bundle between the datapath and the pipeline hazard controller.
//   master : datapath side, drives the ID/EX/MEM status and reads the strobes.
//   slave  : controller side, reads the status and drives the strobes.
//   Status : id_rs, id_rt, id_use_rs, id_use_rt, id_mdu, id_halt,
//            ex_load, ex_rd, ex_br_taken, mem_wait
//   Strobes: pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en,
//            exmem_clr, mdu_busy, halted, stall_cnt
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 5
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_mdu;
    logic             id_halt;
    logic             ex_load;
    logic [REG_W-1:0] ex_rd;
    logic             ex_br_taken;
    logic             mem_wait;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_clr;
    logic             idex_en;
    logic             idex_clr;
    logic             exmem_en;
    logic             exmem_clr;
    logic             mdu_busy;
    logic             halted;
    logic [31:0]      stall_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_mdu, id_halt,
               ex_load, ex_rd, ex_br_taken, mem_wait,
        input  pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en,
               exmem_clr, mdu_busy, halted, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_mdu, id_halt,
               ex_load, ex_rd, ex_br_taken, mem_wait,
        output pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en,
               exmem_clr, mdu_busy, halted, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Sequencer for the PC and the IF/ID, ID/EX, EX/MEM stage registers.
//   Produces per-stage load enables and clear strobes for load-use hazards,
//   taken branches resolved in EX, multi-cycle MDU ops, data-memory wait
//   and HALT.
//   Ports:
//     clk   - pipeline clock, rising edge
//     CLR_n - asynchronous active-low reset
//     hz    - pipeline_hazard_ctrl_if.slave (status in, strobes out)
//   Parameters: MDU_LAT (1..15) cycles the MDU holds EX, REG_W register index width.
//   Optional: define STALL_CNT_EN to build the saturating stall-cycle counter;
//   otherwise stall_cnt is tied to 0.
module pipeline_hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int REG_W   = 5
) (
    input  logic                   clk,
    input  logic                   CLR_n,
    pipeline_hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MDU  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [REG_W-1:0] ex_rd_w;
    logic             load_use;
    logic pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr;

    assign ex_rd_w  = hz.ex_rd;
    assign load_use = hz.ex_load && (ex_rd_w != '0) &&
                      ((hz.id_use_rs && (hz.id_rs == ex_rd_w)) ||
                       (hz.id_use_rt && (hz.id_rt == ex_rd_w)));

    always_comb begin
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        idex_en   = 1'b1;
        exmem_en  = 1'b1;
        ifid_clr  = 1'b0;
        idex_clr  = 1'b0;
        exmem_clr = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        if (!CLR_n) begin
            // Strobes follow reset immediately, not at the next edge.
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            ifid_clr  = 1'b1;
            idex_clr  = 1'b1;
            exmem_clr = 1'b1;
            state_d   = RUN;
            cnt_d     = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (hz.mem_wait) begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        idex_en  = 1'b0;
                        exmem_en = 1'b0;
                    end else if (hz.ex_br_taken) begin
                        ifid_clr = 1'b1;
                        idex_clr = 1'b1;
                    end else if (load_use) begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        idex_clr = 1'b1;
                    end else if (hz.id_mdu) begin
                        state_d = MDU;
                        cnt_d   = 4'(MDU_LAT - 1);
                    end else if (hz.id_halt) begin
                        state_d = HALT;
                    end
                end
                MDU: begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    idex_en = 1'b0;
                    if (hz.mem_wait) begin
                        exmem_en = 1'b0;
                    end else begin
                        // Bubbles enter MEM until the final cycle captures the result.
                        exmem_clr = (cnt_q != '0);
                        if (cnt_q == '0) begin
                            state_d = RUN;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end
                HALT: begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    ifid_clr = 1'b1;
                    // Downstream drains, but a waiting memory still holds it.
                    if (hz.mem_wait) begin
                        idex_en  = 1'b0;
                        exmem_en = 1'b0;
                    end else begin
                        idex_clr = 1'b1;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.pc_en     = pc_en;
    assign hz.ifid_en   = ifid_en;
    assign hz.ifid_clr  = ifid_clr;
    assign hz.idex_en   = idex_en;
    assign hz.idex_clr  = idex_clr;
    assign hz.exmem_en  = exmem_en;
    assign hz.exmem_clr = exmem_clr;
    assign hz.mdu_busy  = (state_q == MDU);
    assign hz.halted    = (state_q == HALT);

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            stall_cnt_q <= '0;
        end else if (!pc_en && (state_q != HALT) && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
`else
    assign hz.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//   Self-checking bench: directed scenarios followed by randomized stimulus,
//   compared each cycle against a behavioural model of the controller.
module tb_pipeline_hazard_ctrl;
    localparam int MDU_LAT = 4;
    localparam int REG_W   = 5;

    logic clk;
    logic CLR_n;

    pipeline_hazard_ctrl_if #(.REG_W(REG_W)) hz ();

    pipeline_hazard_ctrl #(.MDU_LAT(MDU_LAT), .REG_W(REG_W)) dut (
        .clk   (clk),
        .CLR_n (CLR_n),
        .hz    (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_fail;

    // Model state: remaining MDU cycles (0 = not in MDU), halted flag, stall count.
    int          m_mdu_left;
    bit          m_halted;
    logic [31:0] m_stall;

    int unsigned busy_seen;
    int unsigned pc_low_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected strobes packed as {pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
    // exmem_en, exmem_clr, mdu_busy, halted}.
    function automatic logic [8:0] model_strobes();
        logic haz;
        logic [8:0] r;
        haz = hz.ex_load && (hz.ex_rd != 0) &&
              ((hz.id_use_rs && hz.id_rs == hz.ex_rd) || (hz.id_use_rt && hz.id_rt == hz.ex_rd));
        if (!CLR_n)               r = 9'b0_0_1_0_1_0_1_0_0;
        else if (m_halted)        r = hz.mem_wait ? 9'b0_0_1_0_0_0_0_0_1 : 9'b0_0_1_1_1_1_0_0_1;
        else if (m_mdu_left > 0)  r = hz.mem_wait ? 9'b0_0_0_0_0_0_0_1_0
                                                  : {6'b0_0_0_0_0_1, (m_mdu_left > 1), 2'b10};
        else if (hz.mem_wait)     r = 9'b0;
        else if (hz.ex_br_taken)  r = 9'b1_1_1_1_1_1_0_0_0;
        else if (haz)             r = 9'b0_0_0_1_1_1_0_0_0;
        else                      r = 9'b1_1_0_1_0_1_0_0_0;
        return r;
    endfunction

    function automatic logic [31:0] exp_stall();
`ifdef STALL_CNT_EN
        return m_stall;
`else
        return 32'd0;
`endif
    endfunction

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        logic [8:0] e;
        logic [8:0] o;
        logic haz;
        #1;
        e = model_strobes();
        o = {hz.pc_en, hz.ifid_en, hz.ifid_clr, hz.idex_en, hz.idex_clr,
             hz.exmem_en, hz.exmem_clr, hz.mdu_busy, hz.halted};
        check("strobes", {23'd0, o}, {23'd0, e});
        check("stall_cnt", hz.stall_cnt, exp_stall());
        if (hz.mdu_busy) busy_seen++;
        if (!hz.pc_en) pc_low_seen++;
        haz = hz.ex_load && (hz.ex_rd != 0) &&
              ((hz.id_use_rs && hz.id_rs == hz.ex_rd) || (hz.id_use_rt && hz.id_rt == hz.ex_rd));
        @(posedge clk);
        if (!CLR_n) begin
            m_mdu_left = 0;
            m_halted   = 0;
            m_stall    = 0;
        end else begin
            if (!e[8] && !m_halted && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (m_mdu_left > 0) begin
                if (!hz.mem_wait) m_mdu_left--;
            end else if (!m_halted && !hz.mem_wait && !hz.ex_br_taken && !haz) begin
                if (hz.id_mdu)       m_mdu_left = MDU_LAT;
                else if (hz.id_halt) m_halted = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        hz.id_rs = '0; hz.id_rt = '0; hz.id_use_rs = 0; hz.id_use_rt = 0;
        hz.id_mdu = 0; hz.id_halt = 0; hz.ex_load = 0; hz.ex_rd = '0;
        hz.ex_br_taken = 0; hz.mem_wait = 0;
    endtask

    task automatic set_hazard(input logic [REG_W-1:0] rd);
        hz.ex_load = 1; hz.ex_rd = rd; hz.id_use_rs = 1; hz.id_rs = 5;
    endtask

    task automatic reset_pulse();
        CLR_n = 0;
        cycle();
        CLR_n = 1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        m_mdu_left = 0; m_halted = 0; m_stall = 0;
        idle();
        CLR_n = 0;
        @(negedge clk);
        cycle();
        cycle();
        CLR_n = 1;
        cycle();                            // released: normal advance

        // Load-use: exactly one stall cycle, then rd=0 gives none.
        pc_low_seen = 0;
        set_hazard(5); cycle();
        idle(); cycle();
        check("loaduse_stall_cycles", pc_low_seen, 1);
        pc_low_seen = 0;
        set_hazard(0); cycle();
        idle(); cycle();
        check("rd0_no_stall", pc_low_seen, 0);

        // Branch together with a hazard and an MDU op: flush wins, no stall.
        pc_low_seen = 0;
        set_hazard(5); hz.ex_br_taken = 1; hz.id_mdu = 1; cycle();
        idle(); cycle();
        check("branch_over_hazard", pc_low_seen, 0);

        // stall_cnt: reset, one load-use stall, then one MDU op of MDU_LAT cycles.
        reset_pulse();
        set_hazard(5); cycle();
        idle(); hz.id_mdu = 1; cycle();
        idle();
        busy_seen = 0; pc_low_seen = 0;
        for (int i = 0; i < 6; i++) cycle();
        check("mdu_busy_cycles", busy_seen, MDU_LAT);
        check("mdu_pc_low_cycles", pc_low_seen, MDU_LAT);
`ifdef STALL_CNT_EN
        check("stall_cnt_total", hz.stall_cnt, 32'd5);
`else
        check("stall_cnt_total", hz.stall_cnt, 32'd0);
`endif

        // MDU with two mem_wait cycles in the middle.
        hz.id_mdu = 1; cycle();
        hz.id_mdu = 0;
        busy_seen = 0;
        cycle();
        hz.mem_wait = 1; cycle(); cycle();
        hz.mem_wait = 0;
        for (int i = 0; i < 5; i++) cycle();
        check("mdu_busy_wait_cycles", busy_seen, MDU_LAT + 2);

        // Reset asserted mid-MDU takes effect immediately.
        hz.id_mdu = 1; cycle();
        idle(); cycle();
        reset_pulse();
        cycle();

        // HALT, then reset pulse.
        hz.id_halt = 1; cycle();
        idle();
        for (int i = 0; i < 4; i++) cycle();
        check("halted_sticky", {31'd0, hz.halted}, 32'd1);
        hz.mem_wait = 1; cycle();
        hz.mem_wait = 0;
        reset_pulse();
        cycle();
        check("halt_cleared", {31'd0, hz.halted}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            hz.id_rs       = REG_W'($urandom_range(3, 0));
            hz.id_rt       = REG_W'($urandom_range(3, 0));
            hz.ex_rd       = REG_W'($urandom_range(3, 0));
            hz.id_use_rs   = 1'($urandom_range(1, 0));
            hz.id_use_rt   = 1'($urandom_range(1, 0));
            hz.ex_load     = ($urandom_range(99, 0) < 40);
            hz.ex_br_taken = ($urandom_range(99, 0) < 15);
            hz.mem_wait    = ($urandom_range(99, 0) < 20);
            hz.id_mdu      = ($urandom_range(99, 0) < 10);
            hz.id_halt     = ($urandom_range(99, 0) < 3);
            CLR_n          = ($urandom_range(99, 0) >= 4);
            cycle();
        end
        CLR_n = 1;
        idle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers: IF/ID, ID/EX, EX/MEM and the PC.
- Generates per-stage hold (enable) and clear (bubble/flush) strobes for:
  - load-use hazards;
  - taken branches resolved in EX;
  - multi-cycle MDU operations;
  - data-memory wait and HALT.
- Sits beside the datapath; its strobes drive the CLR inputs and load enables of the stage registers.

Parameters:
- MDU_LAT, 4, cycles the MDU occupies EX after issue; legal range 1..15.
- REG_W, 5, register-index width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- CLR_n  in  1  asynchronous active-low reset.
- id_rs  in  REG_W  source register A of the instruction in ID.
- id_rt  in  REG_W  source register B of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_mdu  in  1  ID instruction is a multiply/divide.
- id_halt  in  1  ID instruction is HALT.
- ex_load  in  1  EX instruction is a load.
- ex_rd  in  REG_W  EX destination register.
- ex_br_taken  in  1  branch in EX resolved taken.
- mem_wait  in  1  data memory not ready; MEM must hold.
- pc_en  out  1  PC load enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_clr  out  1  IF/ID clear.
- idex_en  out  1  ID/EX load enable.
- idex_clr  out  1  ID/EX clear (inject bubble).
- exmem_en  out  1  EX/MEM load enable.
- exmem_clr  out  1  EX/MEM clear.
- mdu_busy  out  1  MDU occupying EX.
- halted  out  1  core halted.
- stall_cnt  out  32  stall-cycle counter (only with the optional feature; otherwise tied 0).

Behaviour:
- State register updates on the clk rising edge; CLR_n low resets asynchronously.
- Reset, and while CLR_n is low:
  - state = RUN, MDU counter = 0;
  - pc_en = ifid_en = idex_en = exmem_en = 0;
  - ifid_clr = idex_clr = exmem_clr = 1;
  - mdu_busy = 0, halted = 0, stall_cnt = 0.
- All strobes are combinational from the current state and inputs, so they act in the same cycle. The state transition takes effect on the next edge.
- Load-use hazard: ex_load && ex_rd != 0 && ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd)).
- States: RUN, MDU, HALT.
- RUN, evaluated in priority order:
  1. mem_wait: every _en = 0, every _clr = 0 (freeze all stages). Branch, hazard and MDU detection are ignored this cycle.
  2. ex_br_taken: every _en = 1, ifid_clr = 1, idex_clr = 1, exmem_clr = 0. Flushes the two wrong-path instructions. A simultaneous hazard or id_mdu/id_halt is discarded, because that ID instruction is flushed.
  3. Load-use hazard: pc_en = ifid_en = 0, idex_clr = 1, exmem_en = 1. One-cycle bubble; stay in RUN.
  4. id_mdu: normal advance; the next state is MDU with counter = MDU_LAT−1.
  5. id_halt: normal advance; the next state is HALT.
  6. Otherwise: every _en = 1, every _clr = 0.
- MDU:
  - mdu_busy = 1.
  - pc_en = ifid_en = idex_en = 0; exmem_en = 1 with exmem_clr = 1 (bubbles into MEM).
  - Counter decrements each cycle.
  - At counter == 0: exmem_clr = 0, so the result is captured, and the state returns to RUN.
  - mem_wait in MDU freezes the counter and all enables.
  - ex_br_taken cannot occur in MDU and is ignored.
  - MDU_LAT = 1 means exactly one MDU-state cycle.
- HALT:
  - halted = 1, pc_en = ifid_en = 0, ifid_clr = 1.
  - Downstream stages drain normally (idex_clr = 1 so no new instructions enter EX).
  - Exit only by reset.
- Reset mid-MDU or mid-HALT returns immediately to RUN with the reset output values.
- Register 0 never creates a hazard.

Optional Feature:
- Macro STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 on every cycle with pc_en == 0 while CLR_n is high, excluding HALT cycles;
  - saturates at 0xFFFFFFFF;
  - resets to 0.
- Undefined: no counter register is built; stall_cnt is constant 0.

Test Plan:
- Reset with CLR_n = 0 mid-stream -> all _en = 0, all _clr = 1 immediately (asynchronous). Release -> all _en = 1, all _clr = 0 next cycle.
- Load-use: ex_load = 1, ex_rd = 5, id_use_rs = 1, id_rs = 5 -> exactly one cycle with pc_en = 0, ifid_en = 0, idex_clr = 1. Same with ex_rd = 0 -> no stall.
- Branch and load-use in the same cycle (ex_br_taken = 1 plus the hazard above) -> ifid_clr = idex_clr = 1, pc_en = 1, no stall.
- id_mdu with MDU_LAT = 4 -> mdu_busy high for 4 cycles, pc_en low for 4 cycles. mem_wait asserted for 2 cycles in the middle -> busy extends to 6 cycles.
- id_halt -> halted = 1 from the next cycle, pc_en = 0 thereafter. CLR_n pulse -> halted = 0.
- STALL_CNT_EN defined: one load-use stall plus MDU_LAT = 4 -> stall_cnt = 5. Undefined -> stall_cnt = 0.
